axis_rr_arbiter: RTL
====================

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
Parameters:
REQ-001 N_CH, default 4, number of AXI-Stream input channels (2..16).
REQ-002 DATA_W, default 32, tdata width of every channel and of the output.
REQ-003 USER_W, default 8, tuser width of every channel and of the output.
REQ-004 ID_W, derived as $clog2(N_CH), width of the source-ID output; it SHALL NOT be overridable.
Ports (name  direction  width  meaning):
REQ-005 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 s_tdata  in  N_CH*DATA_W  channel payloads, channel k in slice k.
REQ-008 s_tvalid  in  N_CH  per-channel valid.
REQ-009 s_tready  out  N_CH  per-channel ready.
REQ-010 s_tlast  in  N_CH  per-channel end-of-packet.
REQ-011 s_tuser  in  N_CH*USER_W  per-channel sideband.
REQ-012 m_tdata  out  DATA_W  merged payload.
REQ-013 m_tvalid  out  1  merged valid.
REQ-014 m_tready  in  1  downstream ready.
REQ-015 m_tlast  out  1  merged end-of-packet.
REQ-016 m_tuser  out  USER_W  tuser of the granted channel, passed through unchanged.
REQ-017 m_tid  out  ID_W  index of the channel that sourced the current output beat.
REQ-018 busy  out  1  high while a packet grant is held.
REQ-019 grant_id  out  ID_W  currently granted channel, valid while busy is high.

Function
REQ-020 The arbiter SHALL be packet-atomic: once a channel is granted, only that channel passes beats until its tlast beat handshakes.
REQ-021 The FSM SHALL have two states: IDLE and PASS.
REQ-022 In IDLE, if any s_tvalid bit is high, the FSM SHALL select a winner round-robin, searching from last_grant+1 modulo N_CH, then latch grant_id, set busy and enter PASS on the next edge.
REQ-023 In IDLE, all s_tready bits SHALL be 0, so the arbitration decision costs exactly one cycle.
REQ-024 In PASS, s_tready[grant_id] SHALL equal the output stage's input ready, and all other s_tready bits SHALL be 0.
REQ-025 In PASS, a handshake on the granted channel with s_tlast=1 SHALL update last_grant to grant_id, clear busy and return to IDLE on the same edge.
REQ-026 A granted channel that drops s_tvalid mid-packet SHALL keep the grant; there is no timeout.
REQ-027 Requests arriving while in PASS SHALL NOT preempt the grant; they are considered at the next IDLE cycle.
REQ-028 The output stage SHALL be a full-throughput two-entry register slice (skid buffer): 1-cycle latency from input handshake to m_tvalid, and 1 beat per cycle sustained within a packet.
REQ-029 The register slice SHALL capture {tdata, tlast, tuser, tid} as one word, so m_tid always matches the beat it accompanies.
REQ-030 The register slice SHALL hold m_tdata, m_tlast, m_tuser and m_tid stable while m_tvalid=1 and m_tready=0.
REQ-031 The register slice SHALL NOT deassert m_tvalid without a handshake.
REQ-032 A single-beat packet (tlast on the first beat) SHALL occupy exactly one PASS cycle when m_tready=1.
REQ-033 With all channels continuously requesting, grants SHALL rotate 0,1,2,...,N_CH-1,0.
REQ-034 A lone requester SHALL be re-granted back-to-back, with one IDLE cycle between its packets.

Reset
REQ-035 While rst is high: FSM=IDLE, busy=0, grant_id=0, last_grant=N_CH-1 (so channel 0 wins first), s_tready=0, m_tvalid=0, and m_tdata, m_tlast, m_tuser, m_tid=0.
REQ-036 Reset asserted mid-packet SHALL discard both register-slice entries and the grant; no partial beat SHALL appear after deassertion.

Structure
REQ-037 A shared package daq_axis_pkg SHALL hold the arb_state_e enum (IDLE, PASS) and a default-parameter constant set.
REQ-038 The output stage SHALL be a separate sub-module, axis_reg_slice, parameterised by its total word width and reusable elsewhere in the pipeline.
REQ-039 The top-level ports SHALL map one-to-one onto the axi_if slave (inputs) and master (output) signal sets, so wrappers can attach interfaces directly.

Verification
REQ-040 After reset, ch0 and ch2 each send 3-beat packets simultaneously, m_tready=1 -> ch0 packet appears first (m_tid=0, m_tvalid first high 2 cycles after request), then ch2 (m_tid=2) after a 1-cycle gap.
REQ-041 All 4 channels request continuously with 1-beat packets -> m_tid sequence 0,1,2,3,0,1; no channel starved.
REQ-042 Grant ch1 with an 8-beat packet, m_tready toggling 1,0,1,0 -> all 8 beats emitted in order with no loss or duplication, and outputs stable during m_tready=0.
REQ-043 Grant ch3 while ch0 requests; ch3 drops s_tvalid for 5 cycles mid-packet -> grant stays on ch3 (busy=1, grant_id=3) and ch0 gets s_tready=0 until ch3's tlast handshakes.
REQ-044 Assert rst for 1 cycle on beat 2 of a 4-beat packet -> m_tvalid=0 the next cycle, and after reset the first grant goes to channel 0.

Source files
------------

// File: rtl/daq_axis_pkg.sv
// -----------------------------------------------------------------------------
// daq_axis_pkg
// Shared types and defaults for the AXI-Stream merge path.
//   arb_state_e  : arbiter FSM states (IDLE, PASS)
//   DEF_*        : default parameter set used by the arbiter and its wrappers
//   rr_index     : cyclic index helper for round-robin searches
// -----------------------------------------------------------------------------
package daq_axis_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_e;

  localparam int DEF_N_CH   = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_USER_W = 8;

  // Position 'offset' steps after 'last' on a ring of 'n' entries.
  function automatic int rr_index(input int last, input int offset, input int n);
    return (last + offset) % n;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// -----------------------------------------------------------------------------
// axis_reg_slice
// Two-entry full-throughput register slice (skid buffer) for a valid/ready
// stream carrying an opaque WIDTH-bit word.
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_s_data, i_s_valid   : upstream word and valid
//   o_s_ready             : upstream ready (registered: high while skid empty)
//   o_m_data, o_m_valid   : downstream word and valid (registered)
//   i_m_ready             : downstream ready
// One cycle from upstream handshake to o_m_valid; one word per cycle
// sustained. The output word never changes while stalled and o_m_valid only
// falls after a handshake.
// -----------------------------------------------------------------------------
module axis_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_s_data,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  output logic [WIDTH-1:0] o_m_data,
  output logic             o_m_valid,
  input  logic             i_m_ready
);

  logic [WIDTH-1:0] r_main_data_p0;
  logic             r_main_vld_p0;
  logic [WIDTH-1:0] r_skid_data_p0;
  logic             r_skid_vld_p0;

  logic w_s_hs;
  logic w_main_free;

  // Ready depends only on the skid register, which breaks the combinational
  // ready path from downstream to upstream.
  assign o_s_ready   = ~r_skid_vld_p0;
  assign w_s_hs      = i_s_valid & ~r_skid_vld_p0;
  assign w_main_free = ~r_main_vld_p0 | i_m_ready;

  // ---- stage p0: main output register plus skid overflow register ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_main_data_p0 <= '0;
      r_main_vld_p0  <= 1'b0;
      r_skid_data_p0 <= '0;
      r_skid_vld_p0  <= 1'b0;
    end else begin
      if (w_main_free) begin
        if (r_skid_vld_p0) begin
          // Older word in the skid goes out first; upstream was not ready.
          r_main_data_p0 <= r_skid_data_p0;
          r_main_vld_p0  <= 1'b1;
          r_skid_vld_p0  <= 1'b0;
        end else begin
          r_main_vld_p0 <= w_s_hs;
          if (w_s_hs) begin
            r_main_data_p0 <= i_s_data;
          end
        end
      end else if (w_s_hs) begin
        // Output is stalled: the word accepted this cycle parks in the skid.
        r_skid_data_p0 <= i_s_data;
        r_skid_vld_p0  <= 1'b1;
      end
    end
  end

  assign o_m_data  = r_main_data_p0;
  assign o_m_valid = r_main_vld_p0;

endmodule

// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
// Packet-atomic round-robin merge of N_CH AXI-Stream inputs onto one output.
//   clk, rst                      : clock, asynchronous active-high reset
//   s_tdata/s_tuser               : packed per-channel payload/sideband,
//                                   channel k in slice k
//   s_tvalid/s_tready/s_tlast     : per-channel handshake and end-of-packet
//   m_tdata/m_tuser/m_tlast       : merged beat (through a register slice)
//   m_tvalid/m_tready             : merged handshake
//   m_tid                         : source channel of the current output beat
//   busy, grant_id                : a packet grant is held / granted channel
// An IDLE cycle picks a winner searching from last_grant+1; PASS forwards
// that channel until its tlast beat is accepted. All s_tready are low in
// IDLE, so each packet costs one arbitration cycle.
// -----------------------------------------------------------------------------
module axis_rr_arbiter
  import daq_axis_pkg::*;
#(
  parameter  int N_CH   = DEF_N_CH,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int USER_W = DEF_USER_W,
  localparam int ID_W   = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   s_tdata,
  input  logic [N_CH-1:0]          s_tvalid,
  output logic [N_CH-1:0]          s_tready,
  input  logic [N_CH-1:0]          s_tlast,
  input  logic [N_CH*USER_W-1:0]   s_tuser,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [USER_W-1:0]        m_tuser,
  output logic [ID_W-1:0]          m_tid,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id
);

  localparam int WORD_W = DATA_W + 1 + USER_W + ID_W;

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [ID_W-1:0]   r_grant_id;
  logic [ID_W-1:0]   w_grant_nxt;
  logic [ID_W-1:0]   r_last_grant;
  logic [ID_W-1:0]   w_last_nxt;

  logic              w_slice_vld;
  logic              w_slice_rdy;
  logic [DATA_W-1:0] w_sel_data;
  logic [USER_W-1:0] w_sel_user;
  logic              w_sel_last;
  logic [WORD_W-1:0] w_slice_in;
  logic [WORD_W-1:0] w_slice_out;

  // First requesting channel after 'last', wrapping; 'last' itself is checked
  // last so a lone requester is re-granted.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_CH-1:0] req,
                                              input logic [ID_W-1:0] last);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] cand;
    logic            found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = ID_W'(rr_index(int'(last), i, N_CH));
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Granted-channel payload mux.
  always_comb begin
    w_sel_data = '0;
    w_sel_user = '0;
    w_sel_last = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (ID_W'(k) == r_grant_id) begin
        w_sel_data = s_tdata[k*DATA_W +: DATA_W];
        w_sel_user = s_tuser[k*USER_W +: USER_W];
        w_sel_last = s_tlast[k];
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    w_last_nxt  = r_last_grant;
    s_tready    = '0;
    w_slice_vld = 1'b0;
    case (r_state)
      IDLE: begin
        if (|s_tvalid) begin
          w_grant_nxt = rr_pick(s_tvalid, r_last_grant);
          w_state_nxt = PASS;
        end
      end
      PASS: begin
        s_tready[r_grant_id] = w_slice_rdy;
        w_slice_vld          = s_tvalid[r_grant_id];
        // The tlast handshake releases the grant on the same edge.
        if (w_slice_vld && w_slice_rdy && w_sel_last) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_grant_id;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_last_grant <= ID_W'(N_CH - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
    end
  end

  assign busy     = (r_state == PASS);
  assign grant_id = r_grant_id;

  // ---- stage p0: output register slice; tid travels inside the word ----
  assign w_slice_in = {w_sel_data, w_sel_last, w_sel_user, r_grant_id};

  axis_reg_slice #(
    .WIDTH (WORD_W)
  ) u_out_slice (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_s_data  (w_slice_in),
    .i_s_valid (w_slice_vld),
    .o_s_ready (w_slice_rdy),
    .o_m_data  (w_slice_out),
    .o_m_valid (m_tvalid),
    .i_m_ready (m_tready)
  );

  assign {m_tdata, m_tlast, m_tuser, m_tid} = w_slice_out;

endmodule
